// File: rtl/aes_encrypt_core_pkg.sv
// aes_encrypt_core_pkg: S-box, round primitives and FSM states shared by the AES encryptor
package aes_encrypt_core_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int nr(input int key_bits);
        return key_bits == 256 ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240, v;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        v    = gmul(gmul(a240, a12), a2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i+:8] = sbox(s[8*i+:8]);
        return o;
    endfunction

    // Byte 4c+r is row r of column c; row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r)+:8] = s[8*(4*((c+r)%4)+r)+:8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c+:8];
            a1 = s[32*c+8+:8];
            a2 = s[32*c+16+:8];
            a3 = s[32*c+24+:8];
            o[32*c+:8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8+:8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16+:8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24+:8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        return (last ? t : mix_columns(t)) ^ rk;
    endfunction
endpackage

// File: rtl/aes_encrypt_core_if.sv
// aes_encrypt_core_if: request/response valid-ready bundle for aes_encrypt_core
interface aes_encrypt_core_if #(
    parameter int KEY_BITS = 128
);
    logic                in_valid, in_ready, out_valid, out_ready;
    logic [127:0]        in_data, out_data;
    logic [KEY_BITS-1:0] in_key;
    modport master (output in_valid, in_data, in_key, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, in_key, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_encrypt_core_key_step.sv
// aes_key_step: one combinational AES key-expansion step over a 128- or 256-bit key window
module aes_key_step
    import aes_encrypt_core_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] win,
    input  logic [7:0]          rcon,
    input  logic                odd,
    output logic [KEY_BITS-1:0] wout,
    output logic [7:0]          rcon_out
);
    logic         sub_only;
    logic [31:0]  last, t;
    logic [127:0] fresh;

    // The 256-bit schedule alternates RotWord+rcon steps with SubWord-only steps
    assign sub_only = (KEY_BITS == 256) && odd;
    assign last     = win[KEY_BITS-1 -: 32];
    assign t        = sub_only ? sub_word(last) : sub_word({last[7:0], last[31:8]}) ^ {24'h0, rcon};
    assign fresh[31:0]   = win[31:0] ^ t;
    assign fresh[63:32]  = win[63:32] ^ fresh[31:0];
    assign fresh[95:64]  = win[95:64] ^ fresh[63:32];
    assign fresh[127:96] = win[127:96] ^ fresh[95:64];
    assign rcon_out = sub_only ? rcon : xtime(rcon);

    if (KEY_BITS == 256) begin : g_256
        assign wout = {fresh, win[255:128]};
    end else begin : g_128
        assign wout = fresh;
    end
endmodule

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128/256 encryptor; define AES_ROUND_UNROLL2_EN for two rounds per cycle
module aes_encrypt_core
    import aes_encrypt_core_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input logic               clk,
    input logic               reset_n,
    aes_encrypt_core_if.slave bus
);
    localparam int NR = nr(KEY_BITS);
`ifdef AES_ROUND_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [3:0] LAST = 4'(NR + 1 - STEP);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_encrypt_core: KEY_BITS must be 128 or 256");
    end

    state_t              fsm;
    logic [127:0]        st, nxt_st;
    logic [KEY_BITS-1:0] window, nxt_window, step_a, win_a;
    logic [7:0]          rcon, nxt_rcon, rc_step_a, rc_a;
    logic [3:0]          round;
    logic                skip;

    assign bus.in_ready = fsm == IDLE;

    // 256-bit round 1 uses the upper half of the loaded key without expanding
    assign skip = KEY_BITS == 256 && round == 4'd1;

    aes_key_step #(.KEY_BITS(KEY_BITS)) u_step_a (
        .win(window), .rcon(rcon), .odd(round[0]), .wout(step_a), .rcon_out(rc_step_a)
    );
    assign win_a = skip ? window : step_a;
    assign rc_a  = skip ? rcon : rc_step_a;

`ifdef AES_ROUND_UNROLL2_EN
    logic [KEY_BITS-1:0] win_b;
    logic [7:0]          rc_b;
    logic [127:0]        mid;
    aes_key_step #(.KEY_BITS(KEY_BITS)) u_step_b (
        .win(win_a), .rcon(rc_a), .odd(~round[0]), .wout(win_b), .rcon_out(rc_b)
    );
    assign mid        = enc_round(st, win_a[KEY_BITS-1 -: 128], 1'b0);
    assign nxt_st     = enc_round(mid, win_b[KEY_BITS-1 -: 128], round == LAST);
    assign nxt_window = win_b;
    assign nxt_rcon   = rc_b;
`else
    assign nxt_st     = enc_round(st, win_a[KEY_BITS-1 -: 128], round == LAST);
    assign nxt_window = win_a;
    assign nxt_rcon   = rc_a;
`endif

    // Request capture, round iteration and result hand-off
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm           <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            round         <= '0;
            rcon          <= 8'h01;
        end else begin
            case (fsm)
                IDLE: if (bus.in_valid) begin
                    st     <= bus.in_data ^ bus.in_key[127:0];
                    window <= bus.in_key;
                    round  <= 4'd1;
                    rcon   <= 8'h01;
                    fsm    <= RUN;
                end
                RUN: begin
                    st     <= nxt_st;
                    window <= nxt_window;
                    rcon   <= nxt_rcon;
                    round  <= round + 4'(STEP);
                    if (round == LAST) begin
                        bus.out_data  <= nxt_st;
                        bus.out_valid <= 1'b1;
                        fsm           <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    fsm           <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: FIPS-197 vectors, handshake corner cases and a table-based reference model
module tb_aes_encrypt_core;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
`ifdef AES_ROUND_UNROLL2_EN
    localparam int LAT128 = 5, LAT256 = 7;
`else
    localparam int LAT128 = 10, LAT256 = 14;
`endif
    localparam logic [127:0] PT    = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] K128  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [255:0] K256  = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CT128 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] CT256 = 128'h8960494b9049fceabf456751cab7a28e;

    logic clk = 1'b0, reset_n = 1'b0;
    int passed = 0, total = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_core_if #(.KEY_BITS(128)) a ();
    aes_encrypt_core_if #(.KEY_BITS(256)) b ();
    aes_encrypt_core #(.KEY_BITS(128)) dut128 (.clk(clk), .reset_n(reset_n), .bus(a));
    aes_encrypt_core #(.KEY_BITS(256)) dut256 (.clk(clk), .reset_n(reset_n), .bus(b));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] model128(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] g [4];
        logic [7:0] rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j)+:8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) g[j] = (i % 4 == 0) ? SBOX[w[i-1][(j+1)%4]] : w[i-1][j];
            if (i % 4 == 0) begin
                g[0] = g[0] ^ rc;
                rc = m2(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ g[j];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[8*(r+4*c)+:8] ^ w[c][r];
        for (int n = 1; n <= 10; n++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = SBOX[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = (n == 10 ? t[r][c] :
                               m2(t[r][c]) ^ m2(t[(r+1)%4][c]) ^ t[(r+1)%4][c] ^ t[(r+2)%4][c] ^ t[(r+3)%4][c])
                              ^ w[4*n+c][r];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ct[8*(r+4*c)+:8] = s[r][c];
        return ct;
    endfunction

    // Present a request on the 128-bit core, wait for the accept edge, then scramble the inputs
    task automatic send_a(input logic [127:0] pt, input logic [127:0] key);
        int n;
        a.in_valid = 1'b1;
        a.in_data = pt;
        a.in_key = key;
        n = 0;
        while (!a.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        a.in_valid = 1'b0;
        a.in_data = ~pt;
        a.in_key = ~key;
    endtask

    task automatic wait_out_a(output int lat);
        lat = 0;
        while (!a.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic ok;
        logic [127:0] p1, k1, p2, k2, exp_ct;
        int acc [8];
        a.in_valid = 0; a.in_data = '0; a.in_key = '0; a.out_ready = 0;
        b.in_valid = 0; b.in_data = '0; b.in_key = '0; b.out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", a.in_ready, 1);
        check("rst_out_valid", a.out_valid, 0);
        check("rst_out_data", a.out_data, 0);
        check("rst_in_ready_256", b.in_ready, 1);
        reset_n = 1'b1;

        send_a(PT, K128);
        wait_out_a(lat);
        check("c1_data", a.out_data, CT128);
        check("c1_latency", lat, LAT128);
        check("c1_in_ready_busy", a.in_ready, 0);

        a.in_valid = 1'b1; a.in_data = 128'h1234; a.in_key = 128'h5678;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!a.out_valid || a.out_data !== CT128 || a.in_ready) ok = 1'b0;
        end
        a.in_valid = 1'b0;
        check("bp_hold", ok, 1);
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.out_ready = 1'b0;
        check("bp_release_ready", a.in_ready, 1);
        check("bp_release_valid", a.out_valid, 0);

        b.in_valid = 1'b1; b.in_data = PT; b.in_key = K256;
        @(posedge clk);
        @(negedge clk);
        b.in_valid = 1'b0; b.in_data = '1; b.in_key = '1;
        lat = 0;
        while (!b.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("c3_data", b.out_data, CT256);
        check("c3_latency", lat, LAT256);
        b.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b.out_ready = 1'b0;
        check("c3_release_ready", b.in_ready, 1);

        p1 = {$urandom, $urandom, $urandom, $urandom};
        k1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        send_a(p1, k1);
        repeat (3) @(negedge clk);
        a.in_valid = 1'b1; a.in_data = p2; a.in_key = k2;
        check("busy_in_ready", a.in_ready, 0);
        wait_out_a(lat);
        check("busy_first", a.out_data, model128(p1, k1));
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.out_ready = 1'b0;
        check("busy_idle_ready", a.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a.in_valid = 1'b0; a.in_data = '0; a.in_key = '0;
        wait_out_a(lat);
        check("busy_second", a.out_data, model128(p2, k2));
        check("busy_second_latency", lat, LAT128);
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.out_ready = 1'b0;

        send_a(PT, K128);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_in_ready", a.in_ready, 1);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (a.out_valid) ok = 1'b0;
            @(negedge clk);
        end
        check("abort_no_valid", ok, 1);
        send_a(PT, K128);
        wait_out_a(lat);
        check("abort_c1_data", a.out_data, CT128);
        a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            p1 = {$urandom, $urandom, $urandom, $urandom};
            k1 = {$urandom, $urandom, $urandom, $urandom};
            exp_ct = model128(p1, k1);
            a.in_valid = 1'b1; a.in_data = p1; a.in_key = k1;
            lat = 0;
            while (!a.in_ready && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            @(posedge clk);
            @(negedge clk);
            acc[i] = cyc;
            a.in_data = ~p1; a.in_key = ~k1;
            if (i == 7) a.in_valid = 1'b0;
            wait_out_a(lat);
            check("b2b_data", a.out_data, exp_ct);
        end
        for (int i = 1; i < 8; i++) check("b2b_spacing", acc[i] - acc[i-1], LAT128 + 2);
        a.out_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

Iterative AES block encryptor, parametrised for 128- or 256-bit keys. It uses valid/ready handshakes on both the input and output sides, and can optionally compute two rounds per cycle. The core takes one plaintext block plus key, runs the key schedule on the fly alongside the round datapath, and holds the ciphertext until the consumer takes it. It is the drop-in successor to our fixed AES-128 reset-triggered encryptor and sits between the crypto request FIFO and the result mux.

## Interface
Parameters:
- KEY_BITS, 128: key length. Legal values are 128 (NR=10) and 256 (NR=14); any other value is an elaboration error.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  plaintext/key request valid.
- in_ready  output  1  core can accept a request.
- in_data  input  128  plaintext; AES byte i = in_data[8*i+:8].
- in_key  input  KEY_BITS  cipher key; key byte i = in_key[8*i+:8].
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts the ciphertext.
- out_data  output  128  ciphertext, same byte order as in_data.

## Operation
- Byte order: bytes 4c..4c+3 form state column c.
- State machine: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), decoded combinationally from the state register.
- IDLE:
  - On in_valid && in_ready, capture state <= in_data ^ in_key[127:0] (initial AddRoundKey).
  - Load the full key window with in_key, set round counter = 1 and rcon = 8'h01, then go to RUN.
- RUN, one round per cycle:
  - Rounds 1..NR-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk.
  - Round NR: the same without MixColumns; the result goes to out_data, and the state moves to DONE.
- Round keys, KEY_BITS=128: rk for round r comes from the standard expansion of the 128-bit window. rcon advances each round by xtime (0x80 -> 0x1b).
- Round keys, KEY_BITS=256:
  - The window holds 8 words.
  - Round 1 uses window words 4..7.
  - Later rounds alternate between the RotWord/SubWord/rcon step (even expansion) and the SubWord-only step (odd expansion). rcon advances only on the RotWord steps.
- DONE:
  - out_valid=1; out_data is stable and in_data/in_key are ignored.
  - On out_ready, go to IDLE; in_ready is 1 on the following cycle.
- There is no overlap between requests; a new request is accepted only in IDLE.
- in_data and in_key are sampled only on the accept edge. Changing them afterwards has no effect.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, out_valid=0, out_data=0, round=0, rcon=8'h01. in_ready reads 1 in the cycle after that edge.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid pulse is produced and the partial result is discarded.
- Latency: an accept at edge E0 gives out_valid=1 after edge E0+NR (E0+NR/2 with the unroll macro).
- Throughput: one block per NR+2 cycles when out_ready is held high.
- out_valid stays high, with out_data unchanged, for as long as out_ready is low. There is no timeout.
- An in_valid arriving while busy is held off (in_ready=0); it is not dropped.

## Configuration
- AES_ROUND_UNROLL2_EN:
  - Defined: two round stages are chained combinationally, with two key-schedule steps per cycle and rcon advancing accordingly. RUN takes NR/2 cycles; the final cycle applies one full round followed by the last round (no MixColumns).
  - Undefined: one round per cycle. Ciphertext is identical in both builds; only latency and area differ.

## Structure
- aes_pkg holds:
  - the S-box function and the xtime function;
  - functions for SubBytes, ShiftRows, MixColumns;
  - a function nr(KEY_BITS);
  - the IDLE/RUN/DONE state enum.
- Sub-module aes_key_step: one combinational key-schedule step. It takes the window, rcon and a parity bit (256-bit only), and produces the next window and next rcon. It is instantiated once, or twice under AES_ROUND_UNROLL2_EN.

## Test plan
- FIPS-197 C.1: KEY_BITS=128, in_key=128'h0f0e0d0c0b0a09080706050403020100, in_data=128'hffeeddccbbaa99887766554433221100 -> out_data=128'h5ac5b47080b7cdd830047b6ad8e0c469, with out_valid exactly 10 cycles after accept (5 when unrolled).
- FIPS-197 C.3: KEY_BITS=256, in_key bytes 00..1f (byte i = i), same plaintext -> out_data=128'h896049...b7a28e, i.e. the byte-reversed form of 8ea2b7ca516745bfeafc49904b496089, with latency 14 (7 when unrolled).
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stay stable and in_ready stays 0. Release -> in_ready=1 on the next cycle.
- Busy hold-off: assert in_valid with a different plaintext during RUN -> not accepted. It is accepted after DONE, and both results are correct and delivered in order.
- Reset mid-RUN at round 4 -> out_valid never rises, in_ready=1 after reset, and the next request produces the correct C.1 result.
- Back-to-back: 8 random blocks against a software model with out_ready tied high -> all results match, and accept-to-accept spacing is NR+2 cycles.
